// File: rtl/zx_pager_if.sv
// CPU-side bus and external SRAM pins seen by the zx_pager memory paging unit.
interface zx_pager_if #(
  parameter int ADDR_W = 21
);
  logic              iorq;
  logic              mreq;
  logic              wr;
  logic [15:0]       a;
  logic [7:0]        d;
  logic [ADDR_W-1:0] ramA;
  logic              ramWe;

  modport master (output iorq, mreq, wr, a, d, input ramA, ramWe);
  modport slave  (input iorq, mreq, wr, a, d, output ramA, ramWe);
endinterface

// File: rtl/zx_pager.sv
// ZX Spectrum 128K/+3 memory pager: decodes ports 7FFD/1FFD, merges the divMMC
// overlay and produces the physical SRAM address and write enable.
module zx_pager #(
  parameter int BANK_BITS    = 3,
  parameter int PLUS3        = 0,
  parameter int ADDR_W       = 21,
  parameter int ROM_PAGE     = 64,
  parameter int DIV_ROM_PAGE = 68,
  parameter int DIV_RAM_PAGE = 72
) (
  input  logic       clock,
  input  logic       reset,
  zx_pager_if.slave  bus,
  input  logic       divMap,
  input  logic       divRam,
  input  logic [3:0] divPage,
  output logic       vidPage,
  output logic       locked
);
  localparam logic [4:0] BANK_MASK = 5'((1 << BANK_BITS) - 1);

  logic [7:0] p7ffd;
  logic [2:0] p1ffd;
  logic       wsPrev;
  logic       ws;
  logic       wsRise;
  logic       sel7ffd;
  logic       sel1ffd;
  logic [4:0] bankSel;
  logic [1:0] romIdx;
  logic       special;
  logic       writable;
  int         pageNum;
  int         physAddr;

  assign ws      = !bus.iorq && !bus.wr;
  assign wsRise  = ws && !wsPrev;
  assign sel7ffd = (PLUS3 != 0) ? (bus.a[15:14] == 2'b01 && !bus.a[1])
                                : (!bus.a[15] && !bus.a[1]);
  assign sel1ffd = (PLUS3 != 0) && (bus.a[15:12] == 4'b0001) && !bus.a[1];

  // The lock flag is d[5] of the last accepted 7FFD write: once set, no further
  // write is accepted, so only reset can clear it again.
  assign locked  = p7ffd[5];
  assign vidPage = p7ffd[3];

  // Edge history follows the bus even during reset, so a strobe that spans
  // the release of reset is not mistaken for a fresh I/O write.
  always_ff @(posedge clock) begin
    wsPrev <= ws;
    if (reset) begin
      p7ffd <= '0;
      p1ffd <= '0;
    end else if (wsRise && !locked) begin
      if (sel7ffd) p7ffd <= bus.d;
      if (sel1ffd) p1ffd <= bus.d[2:0];
    end
  end

  // Address translation: pick the 16K page for this quarter, then let the
  // divMMC overlay replace the ROM quarter when it is active.
  always_comb begin
    bankSel  = {p7ffd[7:6], p7ffd[2:0]} & BANK_MASK;
    romIdx   = {(PLUS3 != 0) && p1ffd[2], p7ffd[4]};
    special  = (PLUS3 != 0) && p1ffd[0];
    pageNum  = 0;
    writable = 1'b1;
    if (special) begin
      case (p1ffd[2:1])
        2'd0:    pageNum = int'(bus.a[15:14]);
        2'd1:    pageNum = 4 + int'(bus.a[15:14]);
        2'd2:    pageNum = (bus.a[15:14] == 2'd3) ? 3 : 4 + int'(bus.a[15:14]);
        default: begin
          case (bus.a[15:14])
            2'd0:    pageNum = 4;
            2'd1:    pageNum = 7;
            2'd2:    pageNum = 6;
            default: pageNum = 3;
          endcase
        end
      endcase
    end else begin
      case (bus.a[15:14])
        2'd0: begin
          pageNum  = ROM_PAGE + int'(romIdx);
          writable = 1'b0;
        end
        2'd1:    pageNum = 5;
        2'd2:    pageNum = 2;
        default: pageNum = int'(bankSel);
      endcase
    end
    physAddr = pageNum * 16384 + int'(bus.a[13:0]);
    if (divMap && !special && bus.a[15:14] == 2'b00) begin
      if (bus.a[13]) begin
        physAddr = DIV_RAM_PAGE * 16384 + int'(divPage) * 8192 + int'(bus.a[12:0]);
        writable = 1'b1;
      end else if (divRam) begin
        physAddr = DIV_RAM_PAGE * 16384 + 3 * 8192 + int'(bus.a[12:0]);
        writable = 1'b0;
      end else begin
        physAddr = DIV_ROM_PAGE * 16384 + int'(bus.a[12:0]);
        writable = 1'b0;
      end
    end
  end

  assign bus.ramA  = ADDR_W'(physAddr);
  assign bus.ramWe = !(!bus.mreq && !bus.wr && writable);
endmodule
